// File: rtl/dht_acq_sched_if.sv
// rtl/dht_acq_sched_if.sv - sensor, display and status signals of the acquisition scheduler
interface dht_acq_sched_if;
  logic        sens_start;
  logic        sens_busy;
  logic        sens_done;
  logic [39:0] sens_data;
  logic        disp_req;
  logic        disp_ack;
  logic [7:0]  hum1;
  logic [7:0]  hum2;
  logic [7:0]  temp1;
  logic [7:0]  temp2;
  logic        data_valid;
  logic        err_flag;
  logic [7:0]  err_cnt;

  modport master (
    output sens_start, disp_req, hum1, hum2, temp1, temp2, data_valid, err_flag, err_cnt,
    input  sens_busy, sens_done, sens_data, disp_ack
  );

  modport slave (
    input  sens_start, disp_req, hum1, hum2, temp1, temp2, data_valid, err_flag, err_cnt,
    output sens_busy, sens_done, sens_data, disp_ack
  );
endinterface

// File: rtl/dht_acq_sched.sv
// rtl/dht_acq_sched.sv - periodic DHT11 read trigger, timeout, checksum check and display handoff
module dht_acq_sched #(
  parameter int PERIOD_CYC  = 200_000_000,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input logic             clk,
  input logic             rst,
  dht_acq_sched_if.master bus
);
  localparam int PW = $clog2(PERIOD_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, CHECK, FAIL, DISP} state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [39:0]   shadow;
  logic [7:0]    csum;
  logic          start_pulse;
  logic          disp_req;
  logic          data_valid;
  logic          err_flag;
  logic [7:0]    err_cnt;
  logic [7:0]    hum1, hum2, temp1, temp2;

  // The start pulse must react to sens_busy in the same cycle, so it is the
  // one output decoded from state rather than held in a flop.
  always_comb begin
    start_pulse = rst && (state == START) && !bus.sens_busy;
    csum        = shadow[39:32] + shadow[31:24] + shadow[23:16] + shadow[15:8];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      tcnt       <= '0;
      shadow     <= '0;
      disp_req   <= 1'b0;
      data_valid <= 1'b0;
      err_flag   <= 1'b0;
      err_cnt    <= 8'd0;
      hum1       <= 8'd0;
      hum2       <= 8'd0;
      temp1      <= 8'd0;
      temp2      <= 8'd0;
    end else begin
      // The start cycle itself is count 0, so the next cycle already holds 1.
      if (start_pulse)
        pcnt <= PW'(1);
      else if (pcnt != P_LAST)
        pcnt <= pcnt + PW'(1);

      case (state)
        IDLE: begin
          if (pcnt == P_LAST)
            state <= START;
        end
        START: begin
          if (!bus.sens_busy) begin
            tcnt  <= '0;
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          tcnt <= tcnt + TW'(1);
          if (bus.sens_done) begin
            shadow <= bus.sens_data;
            state  <= CHECK;
          end else if (tcnt == T_LAST) begin
            state <= FAIL;
          end
        end
        CHECK: begin
          if (csum == shadow[7:0]) begin
            hum1       <= shadow[39:32];
            hum2       <= shadow[31:24];
            temp1      <= shadow[23:16];
            temp2      <= shadow[15:8];
            data_valid <= 1'b1;
            err_flag   <= 1'b0;
            disp_req   <= 1'b1;
            state      <= DISP;
          end else begin
            state <= FAIL;
          end
        end
        FAIL: begin
          err_flag <= 1'b1;
          if (err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
          state <= IDLE;
        end
        DISP: begin
          if (bus.disp_ack) begin
            disp_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sens_start = start_pulse;
  assign bus.disp_req   = disp_req;
  assign bus.data_valid = data_valid;
  assign bus.err_flag   = err_flag;
  assign bus.err_cnt    = err_cnt;
  assign bus.hum1       = hum1;
  assign bus.hum2       = hum2;
  assign bus.temp1      = temp1;
  assign bus.temp2      = temp2;
endmodule

// File: doc/dht_acq_sched.md
# dht_acq_sched

Acquisition scheduler between the DHT11 serial reader and the TM1638 display driver. It periodically triggers a sensor read, enforces a read timeout, and validates the 40-bit frame checksum. Validated humidity and temperature bytes are latched onto the `temp1/temp2/hum1/hum2` buses that feed the TM1638 driver, and a display refresh is requested over a req/ack handshake. Failed reads are counted and never reach the display.

## Interface
- `PERIOD_CYC`, default 200_000_000: clk cycles between successive `sens_start` pulses (2 s at 100 MHz). Must be ≥ TIMEOUT_CYC+4.
- `TIMEOUT_CYC`, default 10_000_000: max cycles from `sens_start` to `sens_done` before the read is declared failed.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `sens_start` out 1: one-cycle pulse that starts a DHT11 read.
- `sens_busy` in 1: reader busy; high suppresses `sens_start`.
- `sens_done` in 1: one-cycle pulse; `sens_data` is valid in that cycle.
- `sens_data` in 40: {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first.
- `disp_req` out 1: level; held high until `disp_ack`.
- `disp_ack` in 1: one-cycle pulse from the TM1638 driver when the frame has been sent.
- `hum1`, `hum2`, `temp1`, `temp2` out 8 each: latched hum_int, hum_dec, temp_int, temp_dec.
- `data_valid` out 1: at least one good read since reset.
- `err_flag` out 1: last read failed; cleared by the next good read.
- `err_cnt` out 8: saturating count of failed reads.

## Operation
- Reset (`rst`=0 at an edge): state IDLE, period and timeout counters 0. All outputs are 0.
- Period counter `pcnt`:
  - cleared when `sens_start` pulses; otherwise increments.
  - saturates at PERIOD_CYC-1 and holds there until the next start.
- FSM states:
  - IDLE: if `pcnt`==PERIOD_CYC-1, go to START.
  - START: if `sens_busy`=0, pulse `sens_start`, clear `tcnt`, go to WAIT_DONE. Otherwise stay in START with no pulse.
  - WAIT_DONE: `tcnt` increments.
    - `sens_done`=1: capture `sens_data` into a shadow register, go to CHECK.
    - else if `tcnt`==TIMEOUT_CYC-1: go to FAIL.
    - `sens_done` and timeout in the same cycle: done wins.
  - CHECK: if (hum_int+hum_dec+temp_int+temp_dec) mod 256 == checksum, it is a good read:
    - load the four output bytes.
    - set `data_valid`=1, `err_flag`=0.
    - go to DISP.
    - Otherwise go to FAIL.
  - FAIL (1 cycle): `err_flag`=1, `err_cnt` += 1 saturating at 255. Go to IDLE. No display request; output bytes keep their last good values.
  - DISP: `disp_req`=1. On `disp_ack`=1, go to IDLE; `disp_req` low from the next cycle.
- Ignored inputs:
  - `sens_done` outside WAIT_DONE.
  - `disp_ack` outside DISP.
- Output bytes change only on the CHECK→DISP edge. They are stable whenever `disp_req`=1.
- Reset mid-operation aborts any read or handshake immediately. No pulse is emitted in the reset cycle.

## Timing
- First `sens_start` is in cycle PERIOD_CYC after the first cycle with `rst`=1, provided `sens_busy`=0.
- Steady state: `sens_start` pulses are exactly PERIOD_CYC cycles apart. A start is deferred when:
  - `sens_busy` is high: START waits until it drops.
  - `disp_ack` arrives later than PERIOD_CYC after the start: the start issues 2 cycles after the ack (IDLE→START).
- `sens_done` in cycle N:
  - CHECK in N+1.
  - New bytes, `data_valid`, and `disp_req`=1 visible in N+2.
  - On a bad checksum, `err_flag` and `err_cnt` update in N+3.
- Timeout: `sens_start` in cycle S with no done. FAIL in S+TIMEOUT_CYC+1; `err_flag` and `err_cnt` visible in S+TIMEOUT_CYC+2.
- `disp_ack` in cycle A: `disp_req` low in A+1.

## Test plan
Bench parameters: PERIOD_CYC=100, TIMEOUT_CYC=50.
- Good read: `sens_done` with data 40'h37_00_19_05_55. Required: `hum1`=0x37, `hum2`=0x00, `temp1`=0x19, `temp2`=0x05, `data_valid`=1, `err_flag`=0, `disp_req` high 2 cycles after done, low 1 cycle after ack.
- Bad checksum: data 40'h37_00_19_05_56 after a good read. Required: bytes unchanged, `err_flag`=1, `err_cnt`=1, `disp_req` never asserted, next `sens_start` 100 cycles after the previous one.
- Timeout: no `sens_done`. Required: `err_cnt` increments once, 51 cycles after the start. A `sens_done` injected later in IDLE is ignored.
- Busy and late ack: `sens_busy` high for 30 cycles around the start point delays `sens_start` to the first cycle busy is low. Withholding `disp_ack` for 150 cycles keeps `disp_req` high, with no `sens_start` until 2 cycles after the ack.
- Reset mid-read: `rst`=0 for 1 cycle while in WAIT_DONE. Required: all outputs 0, and the first `sens_start` comes 100 cycles after reset release.
- Saturation: 260 consecutive timeouts. Required: `err_cnt` holds at 255 and `err_flag`=1; a following good read clears `err_flag` while `err_cnt` stays 255.
